cmd_parser: RTL

- Upstream neighbour of the radio control block.
- Assembles 5-byte command-and-control (C&C) frames (C0..C4) from the receive byte stream of the Ethernet/UDP path.
- Decodes each frame into the control-block command bus (cmd_addr, cmd_data, cmd_rqst, cmd_requires_resp, cmd_ptt).
- Buffers up to two decoded commands and rate-limits cmd_rqst pulses, so the I2C and AD9866 SPI engines downstream see a guaranteed minimum spacing between commands.

---
 rtl/cmd_parser.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cmd_parser.sv
// C&C frame assembler and rate-limited command issuer: 5-byte frames are queued (2 deep)
// and issued as cmd_rqst pulses spaced by MIN_GAP cycles. Optional: CMD_PARSER_TIMEOUT_EN.
module cmd_parser #(
  parameter int unsigned MIN_GAP = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  output logic [5:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_requires_resp,
  output logic        cmd_ptt,
  output logic        cmd_rqst,
  output logic [1:0]  q_count,
  output logic [7:0]  err_cnt
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_e;

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  if ((MIN_GAP < 1) || (MIN_GAP > 255) || (TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_param_range
    $error("cmd_parser: MIN_GAP must be 1..255 and TIMEOUT 2..65535");
  end

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [7:0]  frame_q [4];
  logic [39:0] fifo_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [7:0]  gap_q;
  logic [7:0]  err_cnt_q;
  logic [7:0]  err_cnt_d;
  logic [5:0]  cmd_addr_q;
  logic [31:0] cmd_data_q;
  logic        cmd_resp_q;
  logic        cmd_ptt_q;
  logic        cmd_rqst_q;

  logic        sof_abort;
  logic        frame_done;
  logic        pop;
  logic        push;
  logic        drop;
  logic        timeout;
  logic [39:0] frame_word;

`ifdef CMD_PARSER_TIMEOUT_EN
  logic [15:0] idle_q;
  assign timeout = (state_q == S_COLLECT) && !rx_valid && (idle_q == 16'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    sof_abort  = rx_valid && rx_sof && (state_q == S_COLLECT);
    frame_done = rx_valid && !rx_sof && (state_q == S_COLLECT) && (idx_q == 3'd4);
    pop        = (count_q != 2'd0) && (gap_q == 8'd0);
    // A full FIFO still accepts the new frame when an entry leaves on the same edge.
    push       = frame_done && ((count_q != 2'd2) || pop);
    drop       = frame_done && !push;
    frame_word = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], rx_data};

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    err_cnt_d = err_cnt_q;
    if ((sof_abort || drop || timeout) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      gap_q      <= 8'd0;
      err_cnt_q  <= 8'd0;
      cmd_addr_q <= 6'd0;
      cmd_data_q <= 32'd0;
      cmd_resp_q <= 1'b0;
      cmd_ptt_q  <= 1'b0;
      cmd_rqst_q <= 1'b0;
      for (int i = 0; i < 4; i++) frame_q[i] <= 8'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= 40'd0;
`ifdef CMD_PARSER_TIMEOUT_EN
      idle_q     <= 16'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid && rx_sof) begin
            frame_q[0] <= rx_data;
            idx_q      <= 3'd1;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (sof_abort) begin
            frame_q[0] <= rx_data;
            idx_q      <= 3'd1;
          end else if (frame_done) begin
            idx_q   <= 3'd0;
            state_q <= S_IDLE;
          end else if (rx_valid) begin
            frame_q[idx_q[1:0]] <= rx_data;
            idx_q               <= idx_q + 3'd1;
          end else if (timeout) begin
            idx_q   <= 3'd0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (push) begin
        fifo_q[wr_ptr_q] <= frame_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end

      cmd_rqst_q <= pop;
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        cmd_resp_q <= fifo_q[rd_ptr_q][39];
        cmd_addr_q <= fifo_q[rd_ptr_q][38:33];
        cmd_ptt_q  <= fifo_q[rd_ptr_q][32];
        cmd_data_q <= fifo_q[rd_ptr_q][31:0];
        gap_q      <= GAP_LOAD;
      end else if (gap_q != 8'd0) begin
        gap_q <= gap_q - 8'd1;
      end

      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;

`ifdef CMD_PARSER_TIMEOUT_EN
      if ((state_q == S_COLLECT) && !rx_valid && !timeout) begin
        idle_q <= idle_q + 16'd1;
      end else begin
        idle_q <= 16'd0;
      end
`endif
    end
  end

  assign cmd_addr          = cmd_addr_q;
  assign cmd_data          = cmd_data_q;
  assign cmd_requires_resp = cmd_resp_q;
  assign cmd_ptt           = cmd_ptt_q;
  assign cmd_rqst          = cmd_rqst_q;
  assign q_count           = count_q;
  assign err_cnt           = err_cnt_q;

endmodule
